pingpong_rd_sched: RTL and testbench

- Read-side scheduler for two ping-pong line-buffer banks (A/B) of the DAQ/SPI path; each bank is an async RAM FIFO instance.
- Latches each bank's full pulse and drains full banks in strict A/B alternation.
- Issues bank rd_en, merges the banks' dout/valid into one stream through a 4-deep credit-controlled output buffer, and releases each bank when it is drained.
- Sits between the two RAM banks and the SPI transmitter.

---
 rtl/pingpong_pkg.sv | 17 +
 rtl/pingpong_obuf.sv | 69 ++++++
 rtl/pingpong_rd_sched.sv | 208 ++++++++++++++++++++
 tb/tb_pingpong_rd_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared constants for the ping-pong read scheduler.
//   - FSM state encodings (plain localparams so older tools can share them)
//   - bank identifiers as they appear on bank_sel
//   - bank RAM read latency, which bounds the in-flight read count
package pingpong_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BURST   = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    localparam int RAM_RD_LAT = 2;

endpackage

// File: rtl/pingpong_obuf.sv
// Small synchronous first-word-fall-through FIFO that merges the two bank
// streams in front of the SPI transmitter. The head word is always visible
// on dout while empty is low.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write a word
//   pop          consume the head word
//   dout         head word
//   count        number of stored words (0..OBUF_D)
//   full, empty  status flags
module pingpong_obuf #(
    parameter int DATA_W = 8,
    parameter int OBUF_D = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [DATA_W-1:0]           din,
    input  logic                        pop,
    output logic [DATA_W-1:0]           dout,
    output logic [$clog2(OBUF_D):0]     count,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(OBUF_D);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [OBUF_D];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(OBUF_D));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OBUF_D; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The scheduler's credit rule must keep this from ever happening.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/pingpong_rd_sched.sv
// Read-side scheduler for two ping-pong line-buffer banks (A/B). Full pulses
// are latched as pending flags; full banks are drained in strict A/B order,
// their read data merged through a credit-controlled output buffer, and each
// bank is released once fully read.
//
// Build option: define PINGPONG_HDR_EN to prefix every packet with one header
// word {pkt_cnt[DATA_W-2:0], bank_sel}.
//
// Ports:
//   rd_clk, rst_n          clock, asynchronous active-low reset
//   full_a/b               bank full pulses (rd_clk domain)
//   rd_out_a/b             bank fully-read flags
//   valid_a/b, dout_a/b    bank read data, RAM_RD_LAT cycles after rd_en
//   tx_ready               SPI side accepts the head word
//   clr_overrun            clears the sticky overrun flag
//   rd_en_a/b              bank read enables
//   tx_data, tx_valid      merged output stream
//   bank_sel               bank currently owned (0=A, 1=B)
//   release_a/b            one-cycle pulse when a bank is drained
//   busy                   scheduler not idle
//   overrun                full pulse seen on an already pending bank
//   pkt_cnt                drained packet count (wraps)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for the owned bank to become pending
// BURST   | issuing rd_en to the owned bank under the buffer credit rule
// DRAIN   | rd_en held low, waiting for outstanding reads to return
// RELEASE | one cycle: release pulse, pkt_cnt+1, ownership flips
module pingpong_rd_sched
    import pingpong_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DATA_DEPTH = 30,
    parameter int CNT_W      = 16,
    parameter int OBUF_D     = 4
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    input  logic              full_a,
    input  logic              full_b,
    input  logic              rd_out_a,
    input  logic              rd_out_b,
    input  logic              valid_a,
    input  logic              valid_b,
    input  logic [DATA_W-1:0] dout_a,
    input  logic [DATA_W-1:0] dout_b,
    input  logic              tx_ready,
    input  logic              clr_overrun,
    output logic              rd_en_a,
    output logic              rd_en_b,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              bank_sel,
    output logic              release_a,
    output logic              release_b,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  pkt_cnt
);

    localparam int CW  = $clog2(OBUF_D) + 1;
    localparam int SW  = CW + 1;
    localparam int IFW = $clog2(RAM_RD_LAT + 1);
    localparam int WW  = $clog2(DATA_DEPTH + 1);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              full_a_q;
    logic              full_b_q;
    logic              rise_a;
    logic              rise_b;
    logic              pending_a;
    logic              pending_b;
    logic              ovr_evt;
    logic [IFW-1:0]    inflight;
    logic [WW-1:0]     word_cnt;

    logic              pending_s;
    logic              rd_out_s;
    logic              valid_s;
    logic [DATA_W-1:0] dout_s;
    logic              rd_en_s;
    logic              release_s;
    logic              credit_ok;
    logic              start;

    logic [CW-1:0]     buf_count;
    logic              buf_full;
    logic              buf_empty;
    logic              obuf_push;
    logic [DATA_W-1:0] obuf_din;

    assign pending_s = (bank_sel == BANK_B) ? pending_b : pending_a;
    assign rd_out_s  = (bank_sel == BANK_B) ? rd_out_b  : rd_out_a;
    assign valid_s   = (bank_sel == BANK_B) ? valid_b   : valid_a;
    assign dout_s    = (bank_sel == BANK_B) ? dout_b    : dout_a;

    // Reads still in the RAM pipeline already own a buffer slot.
    assign credit_ok = (SW'(buf_count) + SW'(inflight)) < SW'(OBUF_D);
    assign rd_en_s   = (state == BURST) && !rd_out_s && credit_ok;
    assign release_s = (state == RELEASE);

    assign rd_en_a   = rd_en_s   && (bank_sel == BANK_A);
    assign rd_en_b   = rd_en_s   && (bank_sel == BANK_B);
    assign release_a = release_s && (bank_sel == BANK_A);
    assign release_b = release_s && (bank_sel == BANK_B);
    assign busy      = (state != IDLE);
    assign tx_valid  = !buf_empty;

`ifdef PINGPONG_HDR_EN
    // The header is pushed on the IDLE->BURST step, so it carries the bank
    // and packet number of the packet it precedes. Nothing is in flight in
    // IDLE, so it cannot collide with bank data; it only needs a free slot.
    logic              hdr_push;
    logic [DATA_W-1:0] hdr_word;

    assign hdr_word  = {pkt_cnt[DATA_W-2:0], bank_sel};
    assign hdr_push  = (state == IDLE) && pending_s && !buf_full;
    assign start     = hdr_push;
    assign obuf_push = valid_s || hdr_push;
    assign obuf_din  = hdr_push ? hdr_word : dout_s;
`else
    assign start     = (state == IDLE) && pending_s;
    assign obuf_push = valid_s;
    assign obuf_din  = dout_s;
`endif

    assign rise_a  = full_a && !full_a_q;
    assign rise_b  = full_b && !full_b_q;
    assign ovr_evt = (rise_a && pending_a) || (rise_b && pending_b);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)          state_nx = BURST;
            BURST:   if (rd_out_s)       state_nx = DRAIN;
            DRAIN:   if (inflight == '0) state_nx = RELEASE;
            RELEASE:                     state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            full_a_q  <= 1'b0;
            full_b_q  <= 1'b0;
            pending_a <= 1'b0;
            pending_b <= 1'b0;
            overrun   <= 1'b0;
            inflight  <= '0;
            word_cnt  <= '0;
            bank_sel  <= BANK_A;
            pkt_cnt   <= '0;
        end else begin
            state    <= state_nx;
            full_a_q <= full_a;
            full_b_q <= full_b;

            // A new full pulse wins over a same-cycle release.
            if (rise_a)         pending_a <= 1'b1;
            else if (release_a) pending_a <= 1'b0;
            if (rise_b)         pending_b <= 1'b1;
            else if (release_b) pending_b <= 1'b0;

            if (ovr_evt)          overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;

            case ({rd_en_s, valid_s})
                2'b10:   inflight <= inflight + IFW'(1);
                2'b01:   inflight <= inflight - IFW'(1);
                default: inflight <= inflight;
            endcase

            if (state == IDLE)  word_cnt <= '0;
            else if (valid_s)   word_cnt <= word_cnt + WW'(1);

            if (release_s) begin
                pkt_cnt  <= pkt_cnt + CNT_W'(1);
                bank_sel <= ~bank_sel;
            end
        end
    end

    pingpong_obuf #(
        .DATA_W (DATA_W),
        .OBUF_D (OBUF_D)
    ) u_obuf (
        .clk   (rd_clk),
        .rst_n (rst_n),
        .push  (obuf_push),
        .din   (obuf_din),
        .pop   (tx_valid && tx_ready),
        .dout  (tx_data),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    a_inflight_max: assert property (@(posedge rd_clk) disable iff (!rst_n)
        inflight <= IFW'(RAM_RD_LAT));
    a_no_push_full: assert property (@(posedge rd_clk) disable iff (!rst_n)
        !(valid_s && buf_full));
    a_pkt_words:    assert property (@(posedge rd_clk) disable iff (!rst_n)
        (state == RELEASE) |-> (word_cnt == WW'(DATA_DEPTH)));

endmodule

// File: tb/tb_pingpong_rd_sched.sv
module tb_pingpong_rd_sched;

    localparam int DW = 8;
    localparam int DD = 30;

    logic          rd_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          full_a = 1'b0, full_b = 1'b0;
    logic          rd_out_a, rd_out_b;
    logic          valid_a, valid_b;
    logic [DW-1:0] dout_a, dout_b;
    logic          tx_ready = 1'b1;
    logic          clr_overrun = 1'b0;
    logic          rd_en_a, rd_en_b;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          bank_sel;
    logic          release_a, release_b;
    logic          busy;
    logic          overrun;
    logic [15:0]   pkt_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 rd_clk = ~rd_clk;

    pingpong_rd_sched #(
        .DATA_W(DW), .DATA_DEPTH(DD), .CNT_W(16), .OBUF_D(4)
    ) dut (
        .rd_clk(rd_clk), .rst_n(rst_n),
        .full_a(full_a), .full_b(full_b),
        .rd_out_a(rd_out_a), .rd_out_b(rd_out_b),
        .valid_a(valid_a), .valid_b(valid_b),
        .dout_a(dout_a), .dout_b(dout_b),
        .tx_ready(tx_ready), .clr_overrun(clr_overrun),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .bank_sel(bank_sel),
        .release_a(release_a), .release_b(release_b),
        .busy(busy), .overrun(overrun), .pkt_cnt(pkt_cnt)
    );

    // Bank models: word i of bank A is i, of bank B is 0x80+i; 2-cycle read
    // latency; rd_addr rewinds on release.
    int            addr_a, addr_b;
    logic          s1_a, s2_a, s1_b, s2_b;
    logic [DW-1:0] d1_a, d2_a, d1_b, d2_b;

    assign rd_out_a = (addr_a == DD);
    assign rd_out_b = (addr_b == DD);
    assign valid_a  = s2_a;
    assign valid_b  = s2_b;
    assign dout_a   = d2_a;
    assign dout_b   = d2_b;

    always @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_a <= 0; s1_a <= 1'b0; s2_a <= 1'b0; d1_a <= '0; d2_a <= '0;
            addr_b <= 0; s1_b <= 1'b0; s2_b <= 1'b0; d1_b <= '0; d2_b <= '0;
        end else begin
            s1_a <= rd_en_a; s2_a <= s1_a; d2_a <= d1_a;
            s1_b <= rd_en_b; s2_b <= s1_b; d2_b <= d1_b;
            if (rd_en_a) begin
                d1_a   <= 8'(addr_a);
                addr_a <= addr_a + 1;
            end else if (release_a) begin
                addr_a <= 0;
            end
            if (rd_en_b) begin
                d1_b   <= 8'(8'h80 + addr_b);
                addr_b <= addr_b + 1;
            end else if (release_b) begin
                addr_b <= 0;
            end
        end
    end

    // Transfer monitor: values at the falling edge are what the next rising
    // edge will act on.
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] exp_q[$];
    int            max_cnt = 0;

    always @(negedge rd_clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (int'(dut.buf_count) > max_cnt) max_cnt = int'(dut.buf_count);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic pulse_full(input logic a, input logic b);
        full_a = a;
        full_b = b;
        tick();
        full_a = 1'b0;
        full_b = 1'b0;
    endtask

    task automatic add_pkt(input logic bank, input int cnt);
        logic [DW-1:0] h;
`ifdef PINGPONG_HDR_EN
        h = 8'((cnt << 1) | int'(bank));
        exp_q.push_back(h);
`else
        h = '0;
`endif
        for (int i = 0; i < DD; i++) begin
            exp_q.push_back(bank ? 8'(8'h80 + i) : 8'(i));
        end
    endtask

    task automatic clear_q();
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int n, input int budget, input string tag);
        for (int c = 0; c < budget; c++) begin
            tick();
            if (rx_q.size() >= n && !busy && !tx_valid) break;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic cmp_stream(input string tag);
        int nbad;
        int n;
        nbad = 0;
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (rx_q[i] !== exp_q[i]) nbad++;
        end
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        chk({tag, "_bad_words"}, 32'(nbad), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_q();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_c;
        int n_rden;

        tick();
        tick();
        // Reset state
        chk("rst_outs", 32'({rd_en_a, rd_en_b, tx_valid, bank_sel,
                             release_a, release_b, busy, overrun}), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: single bank-A packet, tx_ready held high
        clear_q();
        add_pkt(1'b0, 0);
        rel_c  = -1;
        full_a = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) full_a = 1'b0;
            if (release_a && rel_c < 0) rel_c = c;
        end
        wait_idle(exp_q.size(), 50, "t1");
        chk("t1_release_cycle", 32'(rel_c), 32'd35);
        cmp_stream("t1");
        chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk("t1_bank_sel", 32'(bank_sel), 32'd1);

        // T2: full_b first, full_a 5 cycles later; A is still served first
        do_reset();
        add_pkt(1'b0, 0);
        add_pkt(1'b1, 1);
        pulse_full(1'b0, 1'b1);
        repeat (4) tick();
        pulse_full(1'b1, 1'b0);
        wait_idle(exp_q.size(), 200, "t2");
        cmp_stream("t2");
        chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd2);
        chk("t2_bank_sel", 32'(bank_sel), 32'd0);
        chk("t2_overrun", 32'(overrun), 32'd0);

        // T3: tx_ready high one cycle in four, buffer must fill but not overflow
        clear_q();
        add_pkt(1'b0, 2);
        max_cnt = 0;
        n_rden  = 0;
        full_a  = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tx_ready = (c % 4 == 0);
            tick();
            full_a = 1'b0;
            if (rd_en_a) n_rden++;
            if (rx_q.size() >= exp_q.size() && !busy && !tx_valid) break;
        end
        tx_ready = 1'b1;
        cmp_stream("t3");
        chk("t3_rd_en_count", 32'(n_rden), 32'd30);
        chk("t3_max_buf_count", 32'(max_cnt), 32'd4);
        chk("t3_pkt_cnt", 32'(pkt_cnt), 32'd3);

        // T4: overrun on bank A while B owns the scheduler
        clear_q();
        chk("t4_bank_sel", 32'(bank_sel), 32'd1);
        pulse_full(1'b1, 1'b0);
        tick();
        pulse_full(1'b1, 1'b0);
        tick();
        chk("t4_overrun_set", 32'(overrun), 32'd1);
        chk("t4_no_skip", 32'(busy), 32'd0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("t4_overrun_clr", 32'(overrun), 32'd0);
        full_a      = 1'b1;
        clr_overrun = 1'b1;
        tick();
        full_a      = 1'b0;
        clr_overrun = 1'b0;
        chk("t4_overrun_wins", 32'(overrun), 32'd1);
        add_pkt(1'b1, 3);
        add_pkt(1'b0, 4);
        pulse_full(1'b0, 1'b1);
        wait_idle(exp_q.size(), 300, "t4");
        cmp_stream("t4");
        chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd5);
        chk("t4_overrun_sticky", 32'(overrun), 32'd1);

        // T5: asynchronous reset in the middle of a bank-B burst
        clear_q();
        pulse_full(1'b0, 1'b1);
        for (int c = 0; c < 100; c++) begin
            if (rx_q.size() >= 12) break;
            tick();
        end
        chk("t5_reached_word12", 32'(rx_q.size() >= 12), 32'd1);
        chk("t5_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_outs", 32'({rd_en_a, rd_en_b, tx_valid, bank_sel,
                                  release_a, release_b, busy, overrun}), 32'd0);
        chk("t5_async_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("t5_async_tx_data", 32'(tx_data), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_post_state", 32'({busy, bank_sel}), 32'd0);
        clear_q();
        add_pkt(1'b0, 0);
        pulse_full(1'b1, 1'b0);
        wait_idle(exp_q.size(), 100, "t5");
        cmp_stream("t5_after");
        chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
